// File: rtl/mod_counter_prescaled_if.sv
// Purpose: control/status bundle of the prescaled modulo counter.
//   master : the block that drives the counter (enable, direction, mode,
//            load/clear) and watches its count, terminal-count and done flags.
//   slave  : the counter itself.
// Signals:
//   en        count enable (also gates the prescaler)
//   up        1 = increment, 0 = decrement
//   mode      00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   load      synchronous load of load_val
//   load_val  value to load (clamped to MODULUS-1 by the counter)
//   clear     synchronous clear to 0
//   counter   registered count value
//   tc        registered one-cycle terminal-count pulse
//   done      registered sticky one-shot completion flag
interface mod_counter_prescaled_if #(
  parameter int WIDTH = 5
);
  logic             en;
  logic             up;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clear;
  logic [WIDTH-1:0] counter;
  logic             tc;
  logic             done;

  modport master (
    output en, up, mode, load, load_val, clear,
    input  counter, tc, done
  );

  modport slave (
    input  en, up, mode, load, load_val, clear,
    output counter, tc, done
  );
endinterface

// File: rtl/mod_counter_prescaled.sv
// Purpose: parametrised up/down modulo counter with a clock-enable prescaler,
//   three run modes (wrap, saturate, one-shot), synchronous load and clear,
//   a one-cycle terminal-count pulse and a sticky one-shot done flag.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset (counter, tc, done, prescaler -> 0)
//   bus    mod_counter_prescaled_if.slave: en, up, mode, load, load_val, clear
//          in; counter, tc, done out (all outputs registered)
module mod_counter_prescaled #(
  parameter int WIDTH    = 5,
  parameter int MODULUS  = 32,
  parameter int PRESCALE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  mod_counter_prescaled_if.slave  bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_SAT      = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_WRAP_ALT = 2'b11
  } mode_t;

  logic [WIDTH-1:0] counter_reg, counter_next;
  logic             tc_reg, tc_next;
  logic             done_reg, done_next;
  logic [PW-1:0]    prescaler_reg, prescaler_next;

  logic             step;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_dec;
  logic [WIDTH-1:0] count_step;
  logic [WIDTH-1:0] load_clamped;
  mode_t            mode_sel;

  assign mode_sel = mode_t'(bus.mode);

  // With PRESCALE=1 the prescaler is pinned at 0, so step reduces to en.
  assign step = bus.en && (prescaler_reg == PRE_LAST);

  // Terminal value tracks the direction requested in the current cycle.
  assign term_val = bus.up ? MAX_VAL : '0;

  // Modulo neighbours; wrapping here keeps the count inside 0..MODULUS-1
  // even when MODULUS is smaller than 2**WIDTH.
  assign count_inc  = (counter_reg == MAX_VAL) ? '0 : counter_reg + WIDTH'(1);
  assign count_dec  = (counter_reg == '0) ? MAX_VAL : counter_reg - WIDTH'(1);
  assign count_step = bus.up ? count_inc : count_dec;

  assign load_clamped = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;

  always_comb begin
    counter_next   = counter_reg;
    tc_next        = 1'b0;
    done_next      = done_reg;
    prescaler_next = prescaler_reg;

    if (bus.clear) begin
      counter_next   = '0;
      prescaler_next = '0;
      done_next      = 1'b0;
    end else if (bus.load) begin
      counter_next   = load_clamped;
      prescaler_next = '0;
      done_next      = 1'b0;
    end else if (bus.en) begin
      prescaler_next = step ? '0 : prescaler_reg + PW'(1);
      if (step) begin
        case (mode_sel)
          MODE_SAT: begin
            // Sits at the terminal value; the pulse fires only on arrival.
            if (counter_reg != term_val) begin
              counter_next = count_step;
              tc_next      = (count_step == term_val);
            end
          end
          MODE_ONESHOT: begin
            if (!done_reg) begin
              if (counter_reg == term_val) begin
                // Started on the terminal value: finish silently.
                done_next = 1'b1;
              end else begin
                counter_next = count_step;
                if (count_step == term_val) begin
                  done_next = 1'b1;
                  tc_next   = 1'b1;
                end
              end
            end
          end
          default: begin
            // Wrap (00 and 11). count_step already rolls over at the
            // terminal value; done is left untouched so a finished one-shot
            // can resume counting without losing its flag.
            counter_next = count_step;
            tc_next      = (counter_reg == term_val);
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_reg   <= '0;
      tc_reg        <= 1'b0;
      done_reg      <= 1'b0;
      prescaler_reg <= '0;
    end else begin
      counter_reg   <= counter_next;
      tc_reg        <= tc_next;
      done_reg      <= done_next;
      prescaler_reg <= prescaler_next;
    end
  end

  assign bus.counter = counter_reg;
  assign bus.tc      = tc_reg;
  assign bus.done    = done_reg;

endmodule

// File: tb/tb_mod_counter_prescaled.sv
module tb_mod_counter_prescaled;

  localparam int W = 5;

  typedef struct {
    logic [W-1:0] cnt;
    logic         tc;
    logic         done;
    string        name;
  } exp_t;

  logic clk;
  logic reset;

  int checks = 0;
  int errors = 0;

  exp_t q_a[$];
  exp_t q_p[$];

  mod_counter_prescaled_if #(.WIDTH(W)) bus_a ();
  mod_counter_prescaled_if #(.WIDTH(W)) bus_p ();

  mod_counter_prescaled #(.WIDTH(W), .MODULUS(10), .PRESCALE(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  mod_counter_prescaled #(.WIDTH(W), .MODULUS(10), .PRESCALE(3)) dut_p (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_p.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] got_cnt,
                       input logic got_tc, input logic got_done,
                       input logic [W-1:0] exp_cnt, input logic exp_tc,
                       input logic exp_done);
    checks++;
    if (got_cnt !== exp_cnt || got_tc !== exp_tc || got_done !== exp_done) begin
      errors++;
      $display("FAIL %s: got counter=%0d tc=%0b done=%0b, expected counter=%0d tc=%0b done=%0b",
               name, got_cnt, got_tc, got_done, exp_cnt, exp_tc, exp_done);
    end else begin
      $display("txn %s: counter=%0d tc=%0b done=%0b", name, got_cnt, got_tc, got_done);
    end
  endtask

  // Monitors: one result per clock edge, sampled on the following falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (q_a.size() > 0) begin
        exp_t e;
        e = q_a.pop_front();
        check(e.name, bus_a.counter, bus_a.tc, bus_a.done, e.cnt, e.tc, e.done);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (q_p.size() > 0) begin
        exp_t e;
        e = q_p.pop_front();
        check(e.name, bus_p.counter, bus_p.tc, bus_p.done, e.cnt, e.tc, e.done);
      end
    end
  end

  // Drive one cycle on the PRESCALE=1 counter and queue the post-edge result.
  task automatic cyc(input string name, input logic en, input logic up,
                     input logic [1:0] mode, input logic load,
                     input logic [W-1:0] lv, input logic clear,
                     input logic [W-1:0] ec, input logic etc, input logic edone);
    exp_t e;
    bus_a.en = en; bus_a.up = up; bus_a.mode = mode;
    bus_a.load = load; bus_a.load_val = lv; bus_a.clear = clear;
    e.cnt = ec; e.tc = etc; e.done = edone; e.name = name;
    q_a.push_back(e);
    @(negedge clk);
    #1;
  endtask

  // Same for the PRESCALE=3 counter (always up, wrap mode).
  task automatic cyc_p(input string name, input logic en, input logic clear,
                       input logic [W-1:0] ec);
    exp_t e;
    bus_a.en = 1'b0; bus_a.load = 1'b0; bus_a.clear = 1'b0;
    bus_p.en = en; bus_p.up = 1'b1; bus_p.mode = 2'b00;
    bus_p.load = 1'b0; bus_p.load_val = '0; bus_p.clear = clear;
    e.cnt = ec; e.tc = 1'b0; e.done = 1'b0; e.name = name;
    q_p.push_back(e);
    @(negedge clk);
    #1;
  endtask

  logic [W-1:0] seq2 [11] = '{5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0, 5'd9};
  logic         en6  [8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [W-1:0] cnt6 [8]  = '{5'd0, 5'd0, 5'd0, 5'd1, 5'd1, 5'd1, 5'd1, 5'd2};

  initial begin
    bus_a.en = 1'b0; bus_a.up = 1'b1; bus_a.mode = 2'b00;
    bus_a.load = 1'b0; bus_a.load_val = '0; bus_a.clear = 1'b0;
    bus_p.en = 1'b0; bus_p.up = 1'b1; bus_p.mode = 2'b00;
    bus_p.load = 1'b0; bus_p.load_val = '0; bus_p.clear = 1'b0;
    reset = 1'b1;
    #2;
    check("reset_a", bus_a.counter, bus_a.tc, bus_a.done, 5'd0, 1'b0, 1'b0);
    check("reset_p", bus_p.counter, bus_p.tc, bus_p.done, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    reset = 1'b0;

    // 1: wrap up, 12 cycles
    for (int i = 1; i <= 12; i++) begin
      cyc($sformatf("wrap_up_%0d", i), 1'b1, 1'b1, 2'b00, 1'b0, '0, 1'b0,
          W'(i % 10), (i == 10), 1'b0);
    end

    // 2: wrap down from 0
    cyc("clear2", 1'b1, 1'b0, 2'b00, 1'b0, '0, 1'b1, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      cyc($sformatf("wrap_dn_%0d", i), 1'b1, 1'b0, 2'b00, 1'b0, '0, 1'b0,
          seq2[i], (i == 0 || i == 10), 1'b0);
    end

    // 3: saturate up, 15 cycles
    cyc("clear3", 1'b1, 1'b1, 2'b01, 1'b0, '0, 1'b1, 5'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      cyc($sformatf("sat_up_%0d", i), 1'b1, 1'b1, 2'b01, 1'b0, '0, 1'b0,
          (i >= 9) ? 5'd9 : W'(i), (i == 9), 1'b0);
    end

    // 4: one-shot from load 7, then resume in wrap with done kept, then clear
    cyc("os_load7",  1'b1, 1'b1, 2'b10, 1'b1, 5'd7, 1'b0, 5'd7, 1'b0, 1'b0);
    cyc("os_8",      1'b1, 1'b1, 2'b10, 1'b0, '0,   1'b0, 5'd8, 1'b0, 1'b0);
    cyc("os_9",      1'b1, 1'b1, 2'b10, 1'b0, '0,   1'b0, 5'd9, 1'b1, 1'b1);
    cyc("os_hold1",  1'b1, 1'b1, 2'b10, 1'b0, '0,   1'b0, 5'd9, 1'b0, 1'b1);
    cyc("os_hold2",  1'b1, 1'b1, 2'b10, 1'b0, '0,   1'b0, 5'd9, 1'b0, 1'b1);
    cyc("os_to_wrap",1'b1, 1'b1, 2'b00, 1'b0, '0,   1'b0, 5'd0, 1'b1, 1'b1);
    cyc("os_wrap1",  1'b1, 1'b1, 2'b11, 1'b0, '0,   1'b0, 5'd1, 1'b0, 1'b1);
    cyc("os_clear",  1'b1, 1'b1, 2'b10, 1'b0, '0,   1'b1, 5'd0, 1'b0, 1'b0);

    // 5: clamp, load+clear priority, hold, async reset mid-count
    cyc("load25",    1'b0, 1'b1, 2'b00, 1'b1, 5'd25, 1'b0, 5'd9, 1'b0, 1'b0);
    cyc("hold_en0",  1'b0, 1'b1, 2'b00, 1'b0, '0,    1'b0, 5'd9, 1'b0, 1'b0);
    cyc("load_clr",  1'b1, 1'b1, 2'b00, 1'b1, 5'd5,  1'b1, 5'd0, 1'b0, 1'b0);
    cyc("sat_dn0",   1'b1, 1'b0, 2'b01, 1'b0, '0,    1'b0, 5'd0, 1'b0, 1'b0);
    cyc("load8",     1'b1, 1'b1, 2'b10, 1'b1, 5'd8,  1'b0, 5'd8, 1'b0, 1'b0);
    cyc("os_end9",   1'b1, 1'b1, 2'b10, 1'b0, '0,    1'b0, 5'd9, 1'b1, 1'b1);
    reset = 1'b1;
    #1;
    check("async_reset", bus_a.counter, bus_a.tc, bus_a.done, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    reset = 1'b0;

    // 6: PRESCALE=3 with en gaps, then a clear mid-prescale
    for (int i = 0; i < 8; i++) begin
      cyc_p($sformatf("pre_%0d", i), en6[i], 1'b0, cnt6[i]);
    end
    cyc_p("pre_mid1",  1'b1, 1'b0, 5'd2);
    cyc_p("pre_clear", 1'b1, 1'b1, 5'd0);
    cyc_p("pre_a",     1'b1, 1'b0, 5'd0);
    cyc_p("pre_b",     1'b1, 1'b0, 5'd0);
    cyc_p("pre_c",     1'b1, 1'b0, 5'd1);

    if (q_a.size() != 0 || q_p.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d expected results left unchecked, required 0",
               q_a.size(), q_p.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
